// File: rtl/exp_pkg.sv
// ---------------------------------------------------------------------------
// exp_pkg
//   Constants and types shared by the exponentiation operand loader and its
//   result serializer.
//   - OPW            : operand / result width of the exponentiation core
//   - NUM_OPERANDS   : operands loaded per job
//   - OP_*           : operand slot numbers, in stream load order
//   - loader_state_e : loader FSM state encoding
// ---------------------------------------------------------------------------
package exp_pkg;

  localparam int OPW          = 512;
  localparam int NUM_OPERANDS = 5;

  // Operands arrive on the stream in this order, each one LSW first.
  localparam int OP_MOD    = 0;
  localparam int OP_RMODM  = 1;
  localparam int OP_R2MODM = 2;
  localparam int OP_EXP    = 3;
  localparam int OP_X      = 4;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } loader_state_e;

endpackage

// File: rtl/exp_result_serializer.sv
// ---------------------------------------------------------------------------
// exp_result_serializer
//   Holds the OPW-bit core result and returns it as NW words of DW bits on a
//   valid/ready stream, least significant word first.
//   Ports:
//     clk, resetn   clock, asynchronous active-low reset
//     capture       load capture_data into the result register and start
//                   a new unload (word index restarts at 0)
//     capture_data  OPW-bit core result
//     out_valid     result word valid
//     out_ready     downstream ready
//     out_data      current result word
//     out_last      high while the final word (index NW-1) is presented
//     done          one-cycle pulse: the final word was handshaken
//
//   Handshake: a word transfers on a rising edge where out_valid & out_ready
//   are both high. out_valid never drops and out_data/out_last never change
//   while a word is presented and out_ready is low.
// ---------------------------------------------------------------------------
module exp_result_serializer #(
  parameter int DW  = 64,
  parameter int OPW = 512
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           capture,
  input  logic [OPW-1:0] capture_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic           out_last,
  output logic           done
);

  localparam int NW = OPW / DW;
  localparam int SW = $clog2(NW);

  logic [NW-1:0][DW-1:0] result_q, result_d;
  logic [SW-1:0]         k_q, k_d;
  logic                  valid_q, valid_d;
  logic                  at_last;
  logic                  out_hs;

  assign at_last = (k_q == SW'(NW - 1));
  assign out_hs  = valid_q & out_ready;

  always_comb begin
    result_d = result_q;
    k_d      = k_q;
    valid_d  = valid_q;
    if (capture) begin
      result_d = capture_data;
      k_d      = '0;
      valid_d  = 1'b1;
    end else if (out_hs) begin
      if (at_last) begin
        k_d     = '0;
        valid_d = 1'b0;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_q <= '0;
      k_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      k_q      <= k_d;
      valid_q  <= valid_d;
    end
  end

  // Outputs come straight from registers, so they are stable during stalls.
  assign out_valid = valid_q;
  assign out_data  = result_q[k_q];
  assign out_last  = valid_q & at_last;
  assign done      = out_hs & at_last;

endmodule

// File: rtl/exp_operand_loader.sv
// ---------------------------------------------------------------------------
// exp_operand_loader
//   Word-serial front/back end for the exponentiation core. Collects five
//   OPW-bit operands from a DW-bit input stream, holds them on wide outputs,
//   pulses startExponentiation, captures the result on exp_done and streams
//   it back out DW bits at a time.
//   Ports:
//     clk, resetn            clock, asynchronous active-low reset
//     in_valid/in_ready      input stream handshake
//     in_data                operand word (operands LSW first)
//     in_mult                mode bit, sampled with job word 0 only
//     out_valid/out_ready    result stream handshake
//     out_data, out_last     result word, final-word marker
//     busy                   high in every state except LOAD
//     modulus .. x           operands to the core
//     multiplication_enable  latched in_mult
//     startExponentiation    one-cycle start pulse to the core
//     exp_done, exp_result   core completion pulse and result
//
//   Handshake (both streams): a word transfers on a rising edge where valid
//   and ready are both high; the producer holds data stable until then.
//
//   FSM: LOAD -> START -> WAIT -> UNLOAD -> LOAD. The state is visible through
//   busy (LOAD vs not), startExponentiation (START), out_valid (UNLOAD).
//   DW must be 32, 64 or 128 so that it divides OPW and NW is a power of two.
// ---------------------------------------------------------------------------
module exp_operand_loader #(
  parameter int DW  = 64,
  parameter int OPW = 512
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic           in_mult,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic           out_last,
  output logic           busy,
  output logic [OPW-1:0] modulus,
  output logic [OPW-1:0] Rmodm,
  output logic [OPW-1:0] Rsquaredmodm,
  output logic [OPW-1:0] exponent,
  output logic [OPW-1:0] x,
  output logic           multiplication_enable,
  output logic           startExponentiation,
  input  logic           exp_done,
  input  logic [OPW-1:0] exp_result
);

  import exp_pkg::*;

  localparam int NW   = OPW / DW;
  localparam int NTOT = NUM_OPERANDS * NW;
  localparam int SW   = $clog2(NW);
  localparam int CW   = $clog2(NTOT);
  localparam int IW   = CW - SW;

  typedef logic [NW-1:0][DW-1:0] operand_t;

  loader_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  operand_t      op_q [NUM_OPERANDS];
  operand_t      op_d [NUM_OPERANDS];
  logic          mult_q, mult_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          in_ready_q, in_ready_d;

  logic          in_hs;
  logic          capture;
  logic          unload_done;
  logic [SW-1:0] slot;
  logic [IW-1:0] op_idx;

  // in_ready_q is registered from the next state, so it is high exactly in LOAD.
  assign in_hs   = in_valid & in_ready_q;
  assign capture = exp_done & (state_q == ST_WAIT);

  // NW is a power of two: the low counter bits pick the word within an
  // operand, the high bits pick the operand.
  assign slot   = cnt_q[SW-1:0];
  assign op_idx = cnt_q[CW-1:SW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mult_d  = mult_q;
    for (int i = 0; i < NUM_OPERANDS; i++) begin
      op_d[i] = op_q[i];
    end

    case (state_q)
      ST_LOAD: begin
        if (in_hs) begin
          op_d[op_idx][slot] = in_data;
          if (cnt_q == '0) begin
            mult_d = in_mult;
          end
          if (cnt_q == CW'(NTOT - 1)) begin
            cnt_d   = '0;
            state_d = ST_START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (exp_done) begin
          state_d = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (unload_done) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // Registered outputs are decoded from the next state so they line up
    // with the state they describe.
    start_d    = (state_d == ST_START);
    busy_d     = (state_d != ST_LOAD);
    in_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      mult_q     <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        op_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mult_q     <= mult_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        op_q[i] <= op_d[i];
      end
    end
  end

  exp_result_serializer #(
    .DW  (DW),
    .OPW (OPW)
  ) u_serializer (
    .clk          (clk),
    .resetn       (resetn),
    .capture      (capture),
    .capture_data (exp_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .done         (unload_done)
  );

  assign in_ready              = in_ready_q;
  assign busy                  = busy_q;
  assign startExponentiation   = start_q;
  assign multiplication_enable = mult_q;
  assign modulus               = op_q[OP_MOD];
  assign Rmodm                 = op_q[OP_RMODM];
  assign Rsquaredmodm          = op_q[OP_R2MODM];
  assign exponent              = op_q[OP_EXP];
  assign x                     = op_q[OP_X];

endmodule

// File: tb/tb_exp_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_exp_operand_loader
//   Directed bench for exp_operand_loader (DW=64, NW=8, NTOT=40). Inputs are
//   driven on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_exp_operand_loader;

  localparam int DW   = 64;
  localparam int OPW  = 512;
  localparam int NW   = 8;
  localparam int NTOT = 40;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [DW-1:0]  in_data = '0;
  logic           in_mult = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [DW-1:0]  out_data;
  logic           out_last;
  logic           busy;
  logic [OPW-1:0] modulus, Rmodm, Rsquaredmodm, exponent, x;
  logic           multiplication_enable;
  logic           startExponentiation;
  logic           exp_done = 1'b0;
  logic [OPW-1:0] exp_result = '0;

  always #5 clk = ~clk;

  exp_operand_loader #(.DW(DW), .OPW(OPW)) dut (
    .clk                   (clk),
    .resetn                (resetn),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_data               (in_data),
    .in_mult               (in_mult),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_data              (out_data),
    .out_last              (out_last),
    .busy                  (busy),
    .modulus               (modulus),
    .Rmodm                 (Rmodm),
    .Rsquaredmodm          (Rsquaredmodm),
    .exponent              (exponent),
    .x                     (x),
    .multiplication_enable (multiplication_enable),
    .startExponentiation   (startExponentiation),
    .exp_done              (exp_done),
    .exp_result            (exp_result)
  );

  // ---------------- scoreboard ----------------
  int             tests_run    = 0;
  int             tests_failed = 0;
  logic [DW-1:0]  words [NTOT];
  logic [OPW-1:0] res_a, res_b;

  task automatic check(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected operand built from the current word table: operand op takes
  // words op*NW .. op*NW+NW-1, lowest word in the lowest slice.
  function automatic logic [OPW-1:0] exp_operand(input int op);
    logic [OPW-1:0] v;
    v = '0;
    for (int j = 0; j < NW; j++) v[DW*j +: DW] = words[op*NW + j];
    return v;
  endfunction

  task automatic check_operands(input string tag);
    check({tag, "_modulus"}, modulus,      exp_operand(0));
    check({tag, "_rmodm"},   Rmodm,        exp_operand(1));
    check({tag, "_r2modm"},  Rsquaredmodm, exp_operand(2));
    check({tag, "_exp"},     exponent,     exp_operand(3));
    check({tag, "_x"},       x,            exp_operand(4));
  endtask

  // ---------------- driver tasks (enter and leave on a falling edge) ----------------
  task automatic send_word(input logic [DW-1:0] d, input logic m, input int gap, output int waited);
    waited = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_mult  = m;
    while (in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic load_job(input logic mult, input bit gaps, output int waited0);
    int w;
    waited0 = 0;
    for (int i = 0; i < NTOT; i++) begin
      send_word(words[i], (i == 0) ? mult : 1'b0, gaps ? int'($urandom_range(0, 3)) : 0, w);
      if (i == 0) begin
        waited0 = w;
        check("mult_after_word0", multiplication_enable, mult);
      end
    end
  endtask

  task automatic post_load_checks(input string tag);
    check({tag, "_start_hi"},   startExponentiation, 1'b1);
    check({tag, "_busy_start"}, busy, 1'b1);
    check({tag, "_rdy_start"},  in_ready, 1'b0);
    check_operands(tag);
    @(negedge clk);
    check({tag, "_start_lo"},   startExponentiation, 1'b0);
  endtask

  task automatic run_core(input logic [OPW-1:0] res, input int delay);
    repeat (delay) @(negedge clk);
    check("wait_busy",   busy, 1'b1);
    check("wait_rdy",    in_ready, 1'b0);
    check("wait_ovalid", out_valid, 1'b0);
    check("wait_start",  startExponentiation, 1'b0);
    check_operands("wait");
    exp_done   = 1'b1;
    exp_result = res;
    @(negedge clk);
    exp_done   = 1'b0;
    exp_result = ~res;
  endtask

  task automatic unload_result(input logic [OPW-1:0] res, input bit stall_pattern);
    int   k    = 0;
    int   step = 0;
    logic rdy;
    while (k < NW && step < 200) begin
      rdy       = stall_pattern ? (step % 3 == 0) : 1'b1;
      out_ready = rdy;
      check("out_valid", out_valid, 1'b1);
      check($sformatf("out_data_k%0d", k), out_data, res[DW*k +: DW]);
      check($sformatf("out_last_k%0d", k), out_last, (k == NW - 1));
      @(negedge clk);
      if (rdy) k++;
      step++;
    end
    out_ready = 1'b0;
    check("unload_words", k, NW);
    check("post_unload_rdy",    in_ready, 1'b1);
    check("post_unload_busy",   busy, 1'b0);
    check("post_unload_ovalid", out_valid, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w0;

    for (int k = 0; k < NW; k++) begin
      res_a[DW*k +: DW] = 64'h1111_1111_1111_1111 * 64'(k + 1);
      res_b[DW*k +: DW] = 64'hC0DE_0000_0000_0000 | 64'(k * 3);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy",     busy, 1'b0);
    check("rst_start",    startExponentiation, 1'b0);
    check("rst_ovalid",   out_valid, 1'b0);
    check("rst_olast",    out_last, 1'b0);
    check("rst_mult",     multiplication_enable, 1'b0);
    check("rst_modulus",  modulus, '0);
    check("rst_x",        x, '0);
    resetn = 1'b1;
    @(negedge clk);

    // Reset in the middle of a load
    for (int i = 0; i < NTOT; i++) words[i] = 64'(i);
    for (int i = 0; i < 10; i++) send_word(words[i], (i == 0), 0, w0);
    in_valid = 1'b0;
    check("partial_mod_w0",   modulus[63:0], 64'd0);
    check("partial_mod_w7",   modulus[511:448], 64'd7);
    check("partial_rmodm_w1", Rmodm[127:64], 64'd9);
    check("partial_mult",     multiplication_enable, 1'b1);
    resetn = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_busy",     busy, 1'b0);
    check("midrst_modulus",  modulus, '0);
    check("midrst_rmodm",    Rmodm, '0);
    check("midrst_start",    startExponentiation, 1'b0);
    check("midrst_mult",     multiplication_enable, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // exp_done while idle in LOAD is ignored
    exp_done   = 1'b1;
    exp_result = {OPW{1'b1}};
    @(negedge clk);
    exp_done   = 1'b0;
    @(negedge clk);
    check("idle_done_busy",   busy, 1'b0);
    check("idle_done_rdy",    in_ready, 1'b1);
    check("idle_done_ovalid", out_valid, 1'b0);

    // Job A: w_i = i, multiply mode off
    load_job(1'b0, 1'b0, w0);
    check("a_mod_lsw", modulus[63:0], 64'd0);
    check("a_mod_msw", modulus[511:448], 64'd7);
    check("a_x_msw",   x[511:448], 64'd39);
    post_load_checks("a");
    check("a_mult", multiplication_enable, 1'b0);
    // Keep offering job B word 0 through WAIT and UNLOAD; it must not be taken.
    in_data = 64'hB0B0_0000_0000_0000;
    in_mult = 1'b1;
    run_core(res_a, 6);
    unload_result(res_a, 1'b1);
    check_operands("a_after_unload");
    check("a_mult_after", multiplication_enable, 1'b0);

    // Job B: accepted the cycle after the last result handshake, mult on word 0 only
    for (int i = 0; i < NTOT; i++) words[i] = 64'hB0B0_0000_0000_0000 | 64'(i);
    load_job(1'b1, 1'b0, w0);
    check("b_word0_no_wait", w0, 0);
    post_load_checks("b");
    in_valid = 1'b0;
    check("b_mult_start", multiplication_enable, 1'b1);
    run_core(res_b, 3);
    check("b_mult_unload", multiplication_enable, 1'b1);
    unload_result(res_b, 1'b0);
    check("b_mult_after", multiplication_enable, 1'b1);

    // Job C: w_i = i with random 0-3 cycle gaps, same operands as job A
    for (int i = 0; i < NTOT; i++) words[i] = 64'(i);
    load_job(1'b0, 1'b1, w0);
    post_load_checks("c");
    in_valid = 1'b0;
    run_core(res_a, 2);
    unload_result(res_a, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
